// File: rtl/lsu_mem_if_if.sv
// Data-memory bus between the load/store unit and a word-granular memory.
//   en    : memory enable
//   we    : write enable (write lands on posedge when en=1, we=1)
//   addr  : byte address, word aligned (bits [1:0] are 00)
//   wdata : full-word write data
//   rdata : combinational read data (valid when en=1, we=0)
// master: the load/store unit; slave: the memory.
interface lsu_mem_if_if #(
  parameter int unsigned DATA_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WORD_WIDTH = 32
);
  logic                       en;
  logic                       we;
  logic [DATA_ADDR_WIDTH-1:0] addr;
  logic [DATA_WORD_WIDTH-1:0] wdata;
  logic [DATA_WORD_WIDTH-1:0] rdata;

  modport master (output en, output we, output addr, output wdata, input rdata);
  modport slave  (input en, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store unit: turns core byte/half/word accesses into word-granular
// memory transactions. Sub-word stores are done as read-modify-write; loads
// get lane extraction plus sign/zero extension.
// Ports:
//   clk_i, rst_ni    : clock, synchronous active-low reset
//   req_i / ready_o  : core request handshake (ready only in IDLE)
//   we_i, size_i     : store flag, access size (00 b, 01 h, 10 w, 11 illegal)
//   unsigned_i       : zero-extend loads when 1
//   addr_i, wdata_i  : byte address, right-aligned store data
//   valid_o          : one-cycle response pulse
//   rdata_o, err_o   : load data / misalign-illegal flag, 0 outside valid_o
//   mem              : data-memory bus (master side)
module lsu_mem_if #(
  parameter int unsigned DATA_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WORD_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  output logic                       ready_o,
  input  logic                       we_i,
  input  logic [1:0]                 size_i,
  input  logic                       unsigned_i,
  input  logic [DATA_ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WORD_WIDTH-1:0] wdata_i,
  output logic                       valid_o,
  output logic [DATA_WORD_WIDTH-1:0] rdata_o,
  output logic                       err_o,
  lsu_mem_if_if.master               mem
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_e;

  state_e                     state_q;
  logic                       we_q;
  logic [1:0]                 size_q;
  logic                       uns_q;
  logic                       err_q;
  logic [DATA_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WORD_WIDTH-1:0] wdata_q;
  logic [DATA_WORD_WIDTH-1:0] rdata_q;
  logic [DATA_WORD_WIDTH-1:0] merge_q;

  logic                       misaligned;
  logic [7:0]                 rd_byte;
  logic [15:0]                rd_half;
  logic [DATA_WORD_WIDTH-1:0] ld_ext;
  logic [DATA_WORD_WIDTH-1:0] merge_d;
  logic [DATA_ADDR_WIDTH-1:0] addr_aligned;

  assign addr_aligned = {addr_q[DATA_ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    misaligned = 1'b0;
    case (size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = (addr_i[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Lane select and extension for loads; lane merge for sub-word stores.
  always_comb begin
    rd_byte = mem.rdata[{addr_q[1:0], 3'b000} +: 8];
    rd_half = mem.rdata[{addr_q[1], 4'b0000} +: 16];
    ld_ext  = mem.rdata;
    merge_d = mem.rdata;
    case (size_q)
      2'b00: begin
        ld_ext = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        ld_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
        merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        ld_ext  = mem.rdata;
        merge_d = mem.rdata;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            err_q   <= misaligned;
            rdata_q <= '0;
            merge_q <= '0;
            if (misaligned)          state_q <= RESP;
            else if (!we_i)          state_q <= LOAD;
            else if (size_i == 2'b10) state_q <= WRITE;
            else                     state_q <= RMW_RD;
          end
        end
        LOAD: begin
          rdata_q <= ld_ext;
          state_q <= RESP;
        end
        RMW_RD: begin
          merge_q <= merge_d;
          state_q <= WRITE;
        end
        WRITE:   state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == RESP);
  assign rdata_o = valid_o ? rdata_q : '0;
  assign err_o   = valid_o & err_q;

  // Bus is gated by reset combinationally so a reset cycle can never write.
  always_comb begin
    mem.en    = 1'b0;
    mem.we    = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    if (rst_ni) begin
      case (state_q)
        LOAD, RMW_RD: begin
          mem.en   = 1'b1;
          mem.addr = addr_aligned;
        end
        WRITE: begin
          mem.en    = 1'b1;
          mem.we    = 1'b1;
          mem.addr  = addr_aligned;
          mem.wdata = (size_q == 2'b10) ? wdata_q : merge_q;
        end
        default: begin
          mem.en = 1'b0;
        end
      endcase
    end
  end

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
module tb_lsu_mem_if;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        ready_o;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        unsigned_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  lsu_mem_if_if #(.DATA_ADDR_WIDTH(32), .DATA_WORD_WIDTH(32)) bus ();

  lsu_mem_if #(.DATA_ADDR_WIDTH(32), .DATA_WORD_WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .ready_o    (ready_o),
    .we_i       (we_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .valid_o    (valid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .mem        (bus)
  );

  always #5 clk_i = ~clk_i;

  // Word memory: write on posedge, combinational read.
  logic [31:0] mem_arr [0:255];
  int wr_cnt = 0;
  int en_cnt = 0;
  int acc_cnt = 0;

  assign bus.rdata = (bus.en && !bus.we) ? mem_arr[bus.addr[9:2]] : '0;

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    mem_arr[32'h100 >> 2] = 32'h876543A1;
    forever begin
      @(posedge clk_i);
      if (req_i && ready_o && rst_ni) acc_cnt++;
      if (bus.en) en_cnt++;
      if (bus.en && bus.we) begin
        mem_arr[bus.addr[9:2]] = bus.wdata;
        wr_cnt++;
      end
    end
  end

  // Protocol invariants sampled every cycle.
  int mon_bad = 0;
  always @(negedge clk_i) begin
    if (ready_o && (valid_o || bus.en)) begin
      mon_bad++;
      if (mon_bad < 5) $display("FAIL monitor ready_busy: ready=%0b valid=%0b en=%0b", ready_o, valid_o, bus.en);
    end
    if (bus.en && bus.addr[1:0] != 2'b00) begin
      mon_bad++;
      if (mon_bad < 5) $display("FAIL monitor addr_align: addr=%h", bus.addr);
    end
    if (!bus.en && (bus.we || bus.addr != 0 || bus.wdata != 0)) begin
      mon_bad++;
      if (mon_bad < 5) $display("FAIL monitor idle_bus: we=%0b addr=%h wdata=%h", bus.we, bus.addr, bus.wdata);
    end
    if (!valid_o && (rdata_o != 0 || err_o)) begin
      mon_bad++;
      if (mon_bad < 5) $display("FAIL monitor resp_gate: rdata=%h err=%0b", rdata_o, err_o);
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, little-endian.
  logic [7:0] ref_mem [0:1023];

  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er,
                       output int lat, output int wr, output int en);
    int nb;
    logic [31:0] v;
    nb = 1 << size;
    er = (size == 2'd3) || ((addr % nb) != 0);
    rd = '0; lat = 1; wr = 0; en = 0;
    if (!er) begin
      if (!we) begin
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[(addr + i) % 1024]) << (8 * i));
        if (!uns && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        rd = v; lat = 2; en = 1;
      end else begin
        for (int i = 0; i < nb; i++) ref_mem[(addr + i) % 1024] = wdata[8 * i +: 8];
        lat = (nb == 4) ? 2 : 3;
        wr  = 1;
        en  = (nb == 4) ? 1 : 2;
      end
    end
  endtask

  // One request: wait for ready, accept, then wait for the response pulse.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int wr, output int en);
    int w0, e0;
    @(negedge clk_i);
    for (int i = 0; i < 20 && !ready_o; i++) @(negedge clk_i);
    req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns; addr_i = addr; wdata_i = wdata;
    @(posedge clk_i);
    w0 = wr_cnt; e0 = en_cnt;
    lat = 99; rd = 'x; er = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      if (k == 1) req_i = 1'b0;
      if (valid_o) begin
        lat = k; rd = rdata_o; er = err_o;
        break;
      end
    end
    req_i = 1'b0;
    wr = wr_cnt - w0;
    en = en_cnt - e0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    int          exp_en;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, e_rd;
    logic er, e_er;
    int lat, wr, en, e_lat, e_wr, e_en;
    int w0, a0, nres, k;
    logic vseen;
    logic [31:0] b_addr [4];
    logic [31:0] b_wd [4];
    logic        b_we [4];
    logic [31:0] b_exp [4];
    logic [31:0] b_rd [4];
    int          acc_cyc [4];

    tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h0,        32'hFFFFFFA1, 1'b0, 2, 0, 1};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h100, 32'h0,        32'h000000A1, 1'b0, 2, 0, 1};
    tbl[2]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        32'hFFFF8765, 1'b0, 2, 0, 1};
    tbl[3]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'h00008765, 1'b0, 2, 0, 1};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'h101, 32'h123456CC, 32'h0,        1'b0, 3, 1, 2};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h8765CCA1, 1'b0, 2, 0, 1};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 1};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h104, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 1};
    tbl[8]  = '{1'b1, 2'd1, 1'b0, 32'h106, 32'h0000BEEF, 32'h0,        1'b0, 3, 1, 2};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h104, 32'h0,        32'hBEEFBEEF, 1'b0, 2, 0, 1};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h101, 32'h1111,     32'h0,        1'b1, 1, 0, 0};
    tbl[12] = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 32'h107, 32'h0,        32'hFFFFFFBE, 1'b0, 2, 0, 1};
    tbl[14] = '{1'b0, 2'd1, 1'b1, 32'h104, 32'h0,        32'h0000BEEF, 1'b0, 2, 0, 1};
    tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h8765CCA1, 1'b0, 2, 0, 1};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    ref_mem[32'h100] = 8'hA1; ref_mem[32'h101] = 8'h43;
    ref_mem[32'h102] = 8'h65; ref_mem[32'h103] = 8'h87;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_mem_en", 32'(bus.en), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", 32'(ready_o), 32'd1);

    // Directed table
    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, e_rd, e_er, e_lat, e_wr, e_en);
      do_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, er, lat, wr, en);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_writes", i), 32'(wr), 32'(tbl[i].exp_wr));
      chk($sformatf("tbl%0d_en_cycles", i), 32'(en), 32'(tbl[i].exp_en));
    end

    // Reset while in RMW_RD of sb 0x100: no write, no response
    @(negedge clk_i);
    for (int i = 0; i < 20 && !ready_o; i++) @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'd0; unsigned_i = 1'b0; addr_i = 32'h100; wdata_i = 32'hFF;
    @(posedge clk_i);
    w0 = wr_cnt;
    @(negedge clk_i);
    req_i = 1'b0;
    chk("rmw_read_active", {30'd0, bus.en, bus.we}, 32'd2);
    rst_ni = 1'b0;
    #1;
    chk("rst_cycle_mem_en", 32'(bus.en), 32'd0);
    chk("rst_cycle_mem_we", 32'(bus.we), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("post_rst_ready", 32'(ready_o), 32'd1);
    vseen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (valid_o) vseen = 1'b1;
      @(negedge clk_i);
    end
    chk("post_rst_no_valid", 32'(vseen), 32'd0);
    chk("post_rst_no_write", 32'(wr_cnt - w0), 32'd0);
    model(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, e_rd, e_er, e_lat, e_wr, e_en);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er, lat, wr, en);
    chk("post_rst_lw", rd, 32'h8765CCA1);

    // Back-to-back alternating lw/sw with req_i held high
    b_we[0] = 1'b0; b_addr[0] = 32'h104; b_wd[0] = 32'h0;
    b_we[1] = 1'b1; b_addr[1] = 32'h108; b_wd[1] = 32'h13572468;
    b_we[2] = 1'b0; b_addr[2] = 32'h108; b_wd[2] = 32'h0;
    b_we[3] = 1'b1; b_addr[3] = 32'h10C; b_wd[3] = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      model(b_we[i], 2'd2, 1'b0, b_addr[i], b_wd[i], e_rd, e_er, e_lat, e_wr, e_en);
      b_exp[i] = e_rd;
    end
    w0 = wr_cnt; a0 = acc_cnt; nres = 0; k = 0;
    @(negedge clk_i);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (valid_o && nres < 4) begin
        b_rd[nres] = rdata_o;
        nres++;
      end
      if (ready_o) begin
        if (k < 4) begin
          req_i = 1'b1; we_i = b_we[k]; size_i = 2'd2; unsigned_i = 1'b0;
          addr_i = b_addr[k]; wdata_i = b_wd[k];
          acc_cyc[k] = cyc;
          k++;
        end else begin
          req_i = 1'b0;
        end
      end
      @(negedge clk_i);
    end
    req_i = 1'b0;
    chk("b2b_responses", 32'(nres), 32'd4);
    chk("b2b_accepts", 32'(acc_cnt - a0), 32'd4);
    chk("b2b_writes", 32'(wr_cnt - w0), 32'd2);
    for (int i = 0; i < 4; i++)
      if (i < nres) chk($sformatf("b2b_rdata%0d", i), b_rd[i], b_exp[i]);
    for (int i = 1; i < 4; i++)
      if (i < k) chk($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);

    // Randomized accesses in a small window against the reference model
    for (int n = 0; n < 150; n++) begin
      logic        r_we, r_uns;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wd;
      r_we   = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_addr = 32'h200 + 32'($urandom_range(0, 31));
      r_wd   = $urandom;
      model(r_we, r_size, r_uns, r_addr, r_wd, e_rd, e_er, e_lat, e_wr, e_en);
      do_req(r_we, r_size, r_uns, r_addr, r_wd, rd, er, lat, wr, en);
      chk($sformatf("rnd%0d_rdata", n), rd, e_rd);
      chk($sformatf("rnd%0d_err", n), 32'(er), 32'(e_er));
      chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(e_lat));
      chk($sformatf("rnd%0d_writes", n), 32'(wr), 32'(e_wr));
      chk($sformatf("rnd%0d_en_cycles", n), 32'(en), 32'(e_en));
    end

    // Final memory image vs reference bytes
    for (int a = 32'h100; a < 32'h110; a += 4)
      chk($sformatf("mem_%0h", a), mem_arr[a >> 2],
          {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]});
    for (int a = 32'h200; a < 32'h220; a += 4)
      chk($sformatf("mem_%0h", a), mem_arr[a >> 2],
          {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]});

    chk("monitor_violations", 32'(mon_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
